// File: rtl/handshake_pulse_tx.sv
// Multi-channel event-to-four-phase-handshake transmitter.
// Each channel queues single-cycle events in a saturating pending counter and
// replays them one by one as four-phase req/ack handshakes towards a remote
// clock domain. Ack is synchronized locally; every output is a flop.
module handshake_pulse_tx #(
   parameter int unsigned CH          = 4,
   parameter int unsigned PEND_W      = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] in_pulse,
   input  logic [CH-1:0] ack_in,
   input  logic          err_clr,
   output logic [CH-1:0] req_out,
   output logic [CH-1:0] done_pulse,
   output logic [CH-1:0] busy,
   output logic [CH-1:0] overflow,
   output logic [CH-1:0] timeout_err
);

   // A zero TIMEOUT disables the phase watchdog; keep a 1-bit counter then.
   localparam int unsigned     TmoW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TmoW-1:0] TmoLast = (TIMEOUT > 0) ? TmoW'(TIMEOUT - 1) : '0;
   localparam logic [PEND_W-1:0] PendMax = '1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReqHi = 2'd1,
      StReqLo = 2'd2
   } state_e;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   ack_s;

      state_e                 state_q, state_d;
      logic [PEND_W-1:0]      pend_q, pend_d;
      logic [TmoW-1:0]        tmo_q, tmo_d;
      logic                   abort_q, abort_d;

      logic                   can_launch;
      logic                   launch;
      logic                   complete;
      logic                   tmo_hit;
      logic                   tmo_set;
      logic                   drop;

      logic                   req_q;
      logic                   done_q;
      logic                   busy_q;
      logic                   ovf_q;
      logic                   terr_q;

      // Bring the asynchronous ack into the clk domain.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in[c]};
         end
      end

      assign ack_s = sync_q[SYNC_STAGES-1];

      // Handshake sequencing: next state, launch/complete strobes, watchdog hits.
      always_comb begin
         state_d    = state_q;
         abort_d    = abort_q;
         launch     = 1'b0;
         complete   = 1'b0;
         tmo_set    = 1'b0;
         tmo_hit    = (TIMEOUT != 0) && (tmo_q == TmoLast);
         // A new request may only start once the remote has released ack.
         can_launch = !ack_s && ((pend_q != '0) || in_pulse[c]);

         case (state_q)
            StIdle: begin
               if (can_launch) begin
                  state_d = StReqHi;
                  launch  = 1'b1;
               end
            end
            StReqHi: begin
               if (ack_s) begin
                  state_d = StReqLo;
               end else if (tmo_hit) begin
                  // Give up on this transfer but still walk through the
                  // release phase so the remote sees a clean req fall.
                  state_d = StReqLo;
                  abort_d = 1'b1;
                  tmo_set = 1'b1;
               end
            end
            StReqLo: begin
               if (!ack_s) begin
                  complete = 1'b1;
                  abort_d  = 1'b0;
                  if (can_launch) begin
                     state_d = StReqHi;
                     launch  = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end else if (tmo_hit) begin
                  state_d = StIdle;
                  abort_d = 1'b0;
                  tmo_set = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               abort_d = 1'b0;
            end
         endcase
      end

      // Pending events: +1 per accepted pulse, -1 per launch, saturating at max.
      always_comb begin
         pend_d = pend_q;
         drop   = in_pulse[c] && !launch && (pend_q == PendMax);
         if (in_pulse[c] && !launch && !drop) begin
            pend_d = pend_q + 1'b1;
         end else if (!in_pulse[c] && launch) begin
            pend_d = pend_q - 1'b1;
         end
      end

      // Watchdog counts cycles spent in the current handshake phase.
      always_comb begin
         tmo_d = '0;
         if ((TIMEOUT != 0) && (state_d == state_q) && (state_q != StIdle)) begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      // Channel state registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
         end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
         end
      end

      // Registered outputs; sticky flags give a same-cycle set priority over clear.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            terr_q <= 1'b0;
         end else begin
            req_q  <= (state_d == StReqHi);
            done_q <= complete && !abort_q;
            busy_q <= (state_d != StIdle) || (pend_d != '0);
            ovf_q  <= drop || (ovf_q && !err_clr);
            terr_q <= tmo_set || (terr_q && !err_clr);
         end
      end

      assign req_out[c]     = req_q;
      assign done_pulse[c]  = done_q;
      assign busy[c]        = busy_q;
      assign overflow[c]    = ovf_q;
      assign timeout_err[c] = terr_q;
   end

endmodule

// File: tb/tb_handshake_pulse_tx.sv
// Bench for handshake_pulse_tx: directed scenarios followed by random traffic,
// all outputs compared every cycle against a phase-level reference model.
module tb_handshake_pulse_tx;

   localparam int CH   = 4;
   localparam int PW   = 3;
   localparam int SS   = 2;
   localparam int TMO  = 16;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic [CH-1:0] in_pulse = '0;
   logic [CH-1:0] ack_in   = '0;
   logic          err_clr  = 1'b0;
   logic [CH-1:0] req_out;
   logic [CH-1:0] done_pulse;
   logic [CH-1:0] busy;
   logic [CH-1:0] overflow;
   logic [CH-1:0] timeout_err;

   handshake_pulse_tx #(
      .CH          (CH),
      .PEND_W      (PW),
      .SYNC_STAGES (SS),
      .TIMEOUT     (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_pulse    (in_pulse),
      .ack_in      (ack_in),
      .err_clr     (err_clr),
      .req_out     (req_out),
      .done_pulse  (done_pulse),
      .busy        (busy),
      .overflow    (overflow),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: phase 0 idle, 1 request raised, 2 waiting for ack release.
   int            m_phase [CH];
   int            m_pend  [CH];
   int            m_wait  [CH];
   bit            m_aband [CH];
   bit            ackh    [CH][SS];
   logic [CH-1:0] e_req  = '0;
   logic [CH-1:0] e_done = '0;
   logic [CH-1:0] e_busy = '0;
   logic [CH-1:0] e_ovf  = '0;
   logic [CH-1:0] e_terr = '0;

   // Remote responder: follows the model's request level after a delay.
   bit r_auto [CH];
   int r_cnt  [CH];
   int r_dly  [CH];
   int r_fix  [CH];

   int obs_done [CH];
   int obs_req  [CH];

   task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs == exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         bit s, go, launched, done, set_to, set_ovf;
         int old, tot;
         if (!rst_n) begin
            m_phase[c] = 0;
            m_pend[c]  = 0;
            m_wait[c]  = 0;
            m_aband[c] = 0;
            for (int i = 0; i < SS; i++) ackh[c][i] = 1'b0;
            e_req[c]  = 1'b0;
            e_done[c] = 1'b0;
            e_busy[c] = 1'b0;
            e_ovf[c]  = 1'b0;
            e_terr[c] = 1'b0;
            continue;
         end
         // The ack seen now is the one that arrived SS clocks ago.
         s = ackh[c][SS-1];
         for (int i = SS - 1; i > 0; i--) ackh[c][i] = ackh[c][i-1];
         ackh[c][0] = ack_in[c];

         old      = m_phase[c];
         go       = !s && (m_pend[c] > 0 || in_pulse[c] == 1'b1);
         launched = 0;
         done     = 0;
         set_to   = 0;
         set_ovf  = 0;
         case (old)
            0: if (go) begin m_phase[c] = 1; launched = 1; end
            1: begin
               if (s) m_phase[c] = 2;
               else if (m_wait[c] == TMO - 1) begin
                  m_phase[c] = 2; m_aband[c] = 1; set_to = 1;
               end
            end
            default: begin
               if (!s) begin
                  done       = !m_aband[c];
                  m_aband[c] = 0;
                  if (go) begin m_phase[c] = 1; launched = 1; end
                  else m_phase[c] = 0;
               end else if (m_wait[c] == TMO - 1) begin
                  m_phase[c] = 0; m_aband[c] = 0; set_to = 1;
               end
            end
         endcase

         tot = m_pend[c] + int'(in_pulse[c]) - int'(launched);
         if (tot > PMAX) begin
            tot     = PMAX;
            set_ovf = 1;
         end
         m_pend[c] = tot;
         m_wait[c] = (m_phase[c] != old || old == 0) ? 0 : m_wait[c] + 1;

         e_req[c]  = (m_phase[c] == 1);
         e_done[c] = done;
         e_busy[c] = (m_phase[c] != 0) || (m_pend[c] != 0);
         e_ovf[c]  = set_ovf || (e_ovf[c] && !err_clr);
         e_terr[c] = set_to || (e_terr[c] && !err_clr);
      end
   endtask

   task automatic cycle(input logic [CH-1:0] pin, input logic clr);
      in_pulse = pin;
      err_clr  = clr;
      @(posedge clk);
      model_edge();
      #1;
      check("req_out", req_out, e_req);
      check("done_pulse", done_pulse, e_done);
      check("busy", busy, e_busy);
      check("overflow", overflow, e_ovf);
      check("timeout_err", timeout_err, e_terr);
      for (int c = 0; c < CH; c++) begin
         obs_done[c] += int'(done_pulse[c]);
         obs_req[c]  += int'(req_out[c]);
      end
      in_pulse = '0;
      err_clr  = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (r_auto[c]) begin
            if (e_req[c] != ack_in[c]) begin
               r_cnt[c]++;
               if (r_cnt[c] > r_dly[c]) begin
                  ack_in[c] = e_req[c];
                  r_cnt[c]  = 0;
                  r_dly[c]  = (r_fix[c] >= 0) ? r_fix[c] : int'($urandom_range(0, 15));
               end
            end else begin
               r_cnt[c] = 0;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, 1'b0);
   endtask

   task automatic clear_obs();
      for (int c = 0; c < CH; c++) begin
         obs_done[c] = 0;
         obs_req[c]  = 0;
      end
   endtask

   initial begin
      int lat;
      logic [CH-1:0] pin;
      for (int c = 0; c < CH; c++) begin
         m_phase[c] = 0; m_pend[c] = 0; m_wait[c] = 0; m_aband[c] = 0;
         for (int i = 0; i < SS; i++) ackh[c][i] = 1'b0;
         r_auto[c] = 0; r_cnt[c] = 0; r_dly[c] = 2; r_fix[c] = -1;
      end
      clear_obs();

      // Reset, with ch2's ack already stuck high.
      ack_in[2] = 1'b1;
      cycle(4'b1111, 1'b0);
      idle(2);
      check("reset_outputs", req_out | done_pulse | busy | overflow | timeout_err, '0);
      rst_n = 1'b1;
      idle(4);

      // Stuck ack: event is held pending until ack falls.
      cycle(4'b0100, 1'b0);
      check_int("stuck_busy", int'(busy[2]), 1);
      check_int("stuck_noreq", int'(req_out[2]), 0);
      ack_in[2] = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         cycle('0, 1'b0);
         lat++;
         if (req_out[2]) break;
      end
      check_int("stuck_launch_latency", lat, SS + 1);
      r_auto[2] = 1;
      idle(50);

      // Single event on ch0.
      r_auto[0] = 1; r_fix[0] = 2; r_dly[0] = 2;
      clear_obs();
      cycle(4'b0001, 1'b0);
      check_int("single_req_latency", int'(req_out[0]), 1);
      idle(30);
      check_int("single_done_count", obs_done[0], 1);
      check_int("single_busy_after", int'(busy[0]), 0);

      // Burst of five on ch1.
      r_auto[1] = 1; r_fix[1] = 1; r_dly[1] = 1;
      clear_obs();
      for (int i = 0; i < 5; i++) cycle(4'b0010, 1'b0);
      idle(80);
      check_int("burst_done_count", obs_done[1], 5);
      check_int("burst_no_overflow", int'(overflow[1]), 0);

      // Saturation on ch1: ack held low while ten events arrive.
      r_auto[1] = 0;
      clear_obs();
      for (int i = 0; i < 10; i++) cycle(4'b0010, 1'b0);
      check_int("sat_overflow", int'(overflow[1]), 1);
      r_auto[1] = 1;
      idle(150);
      check_int("sat_done_count", obs_done[1], 1 + PMAX);

      // Timeout on ch2: remote never acknowledges.
      r_auto[2] = 0;
      ack_in[2] = 1'b0;
      idle(5);
      clear_obs();
      cycle(4'b0100, 1'b0);
      idle(40);
      check_int("tmo_req_high_cycles", obs_req[2], TMO);
      check_int("tmo_no_done", obs_done[2], 0);
      check_int("tmo_flag", int'(timeout_err[2]), 1);
      cycle('0, 1'b1);
      check_int("tmo_flag_cleared", int'(timeout_err[2]), 0);

      // Reset in the middle of a handshake on ch3 with two events pending.
      r_auto[3] = 0;
      ack_in[3] = 1'b0;
      for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b0);
      check_int("mid_req_high", int'(req_out[3]), 1);
      rst_n = 1'b0;
      cycle(4'b1000, 1'b0);
      check("mid_reset_outputs", req_out | done_pulse | busy | overflow | timeout_err, '0);
      rst_n = 1'b1;
      clear_obs();
      r_auto[3] = 1;
      idle(20);
      check_int("mid_no_done", obs_done[3], 0);
      check_int("mid_idle_busy", int'(busy[3]), 0);

      // Random traffic on all channels, one reset in the middle.
      for (int c = 0; c < CH; c++) begin
         r_auto[c] = 1;
         r_fix[c]  = -1;
      end
      for (int i = 0; i < 700; i++) begin
         for (int c = 0; c < CH; c++) pin[c] = ($urandom_range(0, 9) < 3);
         if (i == 350) rst_n = 1'b0;
         if (i == 352) rst_n = 1'b1;
         cycle(pin, $urandom_range(0, 19) == 0);
      end
      idle(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
